// File: rtl/dmem_pkg.sv
// dmem_pkg: funct3 encodings plus the lane-mask, store-replication, alignment and load-extension helpers.
package dmem_pkg;
    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    function automatic logic is_byte(input logic [2:0] f3);
        return (f3 == F3_B) || (f3 == F3_BU);
    endfunction

    function automatic logic is_half(input logic [2:0] f3);
        return (f3 == F3_H) || (f3 == F3_HU);
    endfunction

    // Reserved encodings fall through to a full-word access.
    function automatic logic [3:0] lane_mask(input logic [2:0] f3, input logic [1:0] a);
        return is_byte(f3) ? 4'b0001 << a : is_half(f3) ? (a[1] ? 4'b1100 : 4'b0011) : 4'b1111;
    endfunction

    function automatic logic [31:0] store_replicate(input logic [2:0] f3, input logic [31:0] d);
        return is_byte(f3) ? {4{d[7:0]}} : is_half(f3) ? {2{d[15:0]}} : d;
    endfunction

    function automatic logic misaligned(input logic [2:0] f3, input logic [1:0] a);
        return (is_half(f3) && a[0]) || ((f3 == F3_W) && (a != 2'b00));
    endfunction

    function automatic logic [31:0] load_extend(input logic [31:0] word, input logic [1:0] lane,
                                                input logic [2:0] f3);
        logic [7:0]  b;
        logic [15:0] h;
        b = word[8*lane +: 8];
        h = lane[1] ? word[31:16] : word[15:0];
        return (f3 == F3_B)  ? {{24{b[7]}}, b} :
               (f3 == F3_BU) ? {24'd0, b} :
               (f3 == F3_H)  ? {{16{h[15]}}, h} :
               (f3 == F3_HU) ? {16'd0, h} : word;
    endfunction
endpackage

// File: rtl/load_ext.sv
// load_ext: combinational extract and sign/zero extension of a byte/half/word by lane and funct3.
module load_ext
    import dmem_pkg::*;
(
    input  logic [31:0] i_word,
    input  logic [1:0]  i_lane,
    input  logic [2:0]  i_funct3,
    output logic [31:0] o_data
);
    assign o_data = load_extend(i_word, i_lane, i_funct3);
endmodule

// File: rtl/data_mem_resp.sv
// data_mem_resp: single-port data RAM with byte/half/word stores and registered extended loads.
// Define DMEM_ALIGN_CHECK_EN to suppress misaligned H/HU/W accesses and pulse misalign.
module data_mem_resp
    import dmem_pkg::*;
#(
    parameter int DEPTH  = 1024,
    parameter int ADDR_W = $clog2(DEPTH)
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        en,
    input  logic        we,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    input  logic [2:0]  funct3,
    output logic [31:0] rdata,
    output logic        rvalid,
    output logic        misalign
);
    logic [31:0]       r_mem [DEPTH];
    logic [31:0]       r_rdata;
    logic              r_rvalid;
    logic              r_mis;
    logic [ADDR_W-1:0] w_idx;
    logic [3:0]        w_mask;
    logic [31:0]       w_wrep;
    logic [31:0]       w_ld;
    logic              w_mis;
    logic              w_wr;
    logic              w_rd;
    logic              w_unused;

    assign w_unused = ^addr[31:ADDR_W+2];
    assign w_idx    = addr[ADDR_W+1:2];
    assign w_mask   = lane_mask(funct3, addr[1:0]);
    assign w_wrep   = store_replicate(funct3, wdata);
`ifdef DMEM_ALIGN_CHECK_EN
    assign w_mis    = misaligned(funct3, addr[1:0]);
`else
    assign w_mis    = 1'b0;
`endif
    assign w_wr     = en & we & ~w_mis;
    assign w_rd     = en & ~we;

    load_ext u_load_ext (
        .i_word   (r_mem[w_idx]),
        .i_lane   (addr[1:0]),
        .i_funct3 (funct3),
        .o_data   (w_ld)
    );

    // The array has no reset so its contents survive rst.
    always_ff @(posedge clk) begin
        if (w_wr)
            for (int i = 0; i < 4; i++)
                if (w_mask[i]) r_mem[w_idx][8*i +: 8] <= w_wrep[8*i +: 8];
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rdata  <= '0;
            r_rvalid <= 1'b0;
            r_mis    <= 1'b0;
        end else begin
            r_rvalid <= w_rd;
            r_mis    <= en & w_mis;
            if (w_rd) r_rdata <= w_mis ? '0 : w_ld;
        end
    end

    assign rdata    = r_rdata;
    assign rvalid   = r_rvalid;
    assign misalign = r_mis;
endmodule

// File: doc/data_mem_resp.md
Name: data_mem_resp

Overview:
- Data-memory responder: the memory side of the CPU's data port (datamem_en / datamem_we / address / store data / load data).
- Single-port synchronous RAM with byte/halfword/word stores and sign/zero-extended loads selected by the RV32I funct3.
- Registered read data with a one-cycle valid strobe.
- Instantiated beside the CPU in the SoC top; replaces a bare block-RAM IP on the data side.

Parameters:
- DEPTH, 1024, number of 32-bit words in the array (power of two).
- ADDR_W, 10, log2(DEPTH); word-index width.

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  asynchronous, active-high reset
- en  input  1  access request this cycle (CPU datamem_en)
- we  input  1  write when en=1 (CPU datamem_we); read when en=1, we=0
- addr  input  32  byte address (CPU ALU result)
- wdata  input  32  store data, unshifted, in low bits (CPU rs2)
- funct3  input  3  000 B, 001 H, 010 W, 100 BU, 101 HU
- rdata  output  32  extended load data, registered
- rvalid  output  1  one-cycle strobe: rdata updated by a read
- misalign  output  1  one-cycle strobe; permanently 0 unless DMEM_ALIGN_CHECK_EN is defined

Behaviour:
- Reset (async, rst=1): rdata=0, rvalid=0, misalign=0. The array is not cleared; its contents survive reset.
- Index: word = addr[ADDR_W+1:2]. Upper address bits are ignored, so addresses wrap modulo DEPTH*4.
- Write (en=1, we=1), committed at the clock edge:
  - B: lane addr[1:0] gets wdata[7:0].
  - H: lanes {addr[1],0} and {addr[1],1} get wdata[15:0].
  - W: all lanes get wdata.
  - Unselected lanes are unchanged.
  - rvalid=0 next cycle; rdata holds its value.
- Read (en=1, we=0): one cycle of latency.
  - On the edge, the selected byte or half is extracted by addr[1:0] / addr[1].
  - B / H sign-extend; BU / HU zero-extend; W is passed through.
  - The result is registered into rdata, and rvalid=1 for exactly that following cycle.
- Idle (en=0): rvalid=0 next cycle, rdata holds, no array change.
- Reserved funct3 (011, 110, 111):
  - Write behaves as W.
  - Read returns the full word, unextended.
- Back-to-back write then read of the same word: the read returns the newly written data.
- Single port: one operation per cycle, so there is no intra-cycle read/write collision.
- Reset asserted mid-access: the registered outputs clear. A write committed on the same edge that reset asserts is not guaranteed.
- Misaligned access with the macro absent:
  - H uses addr[1] only (addr[0] ignored).
  - W ignores addr[1:0].

Optional Feature:
- Macro DMEM_ALIGN_CHECK_EN. When defined, an access is misaligned if either:
  - it is H/HU with addr[0]=1, or
  - it is W with addr[1:0]≠0.
- A misaligned access:
  - suppresses the write (array unchanged);
  - on a read, sets rdata=0 and rvalid=1 next cycle;
  - in both cases pulses misalign=1 for the next cycle.
- When the macro is undefined, misalign is tied 0 and the truncation rules above apply.

Decomposition:
- Shared package dmem_pkg:
  - funct3 localparams F3_B, F3_H, F3_W, F3_BU, F3_HU;
  - byte-lane mask function lane_mask(funct3, addr[1:0]) returning 4 bits;
  - load extension function.
- One natural sub-module, load_ext: combinational extract and extend of (word, addr[1:0], funct3) → 32-bit. It is reusable by the instruction-side and any future MMIO responder.

Test Plan:
- Reset: assert rst asynchronously mid-cycle → rdata=0, rvalid=0, misalign=0 immediately. Release rst; a read of a word written before reset returns its old value.
- Word round-trip: SW 0xDEADBEEF @0x10, then LW @0x10 → next cycle rdata=0xDEADBEEF, rvalid=1 for one cycle only.
- Byte lanes:
  - SB 0x80 @0x13 over 0x00000000 → LW @0x10 = 0x80000000.
  - LB @0x13 = 0xFFFFFF80.
  - LBU @0x13 = 0x00000080.
- Halfword:
  - SH 0x1234ABCD @0x22 → LW @0x20 = 0xABCD0000.
  - LH @0x22 = 0xFFFFABCD.
  - LHU @0x22 = 0x0000ABCD.
- Wrap: SW 0x55 @(DEPTH*4 + 0x8) → LW @0x8 = 0x00000055.
- Misaligned SW 0x11111111 @0x41 over 0x0:
  - with DMEM_ALIGN_CHECK_EN: misalign=1 one cycle, LW @0x40 = 0.
  - without the macro: LW @0x40 = 0x11111111, misalign=0.
